// File: rtl/accum_pkg.sv
// Shared types for the accumulator responder: call opcodes, FSM states and default width.
package accum_pkg;
  localparam int WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_LOAD = 3'd3,
    OP_CLR  = 3'd4,
    OP_MUL  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;
endpackage

// File: rtl/accum_mul_seq.sv
// Iterative shift-add multiplier: operands latched on start, one partial product per cycle for WIDTH cycles.
module accum_mul_seq
  import accum_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] partial;

  always_comb begin
    partial = prod_q + (mplier[0] ? mcand : '0);
  end

  // done marks the cycle performing the final iteration; product is valid then.
  assign done    = (cnt == CW'(1));
  assign product = partial;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      mcand  <= '0;
      prod_q <= '0;
      mplier <= '0;
    end else if (start) begin
      cnt    <= CW'(WIDTH);
      mcand  <= {{WIDTH{1'b0}}, a};
      prod_q <= '0;
      mplier <= b;
    end else if (cnt != '0) begin
      cnt    <= cnt - CW'(1);
      mcand  <= mcand << 1;
      prod_q <= partial;
      mplier <= mplier >> 1;
    end
  end
endmodule

// File: rtl/accum_responder.sv
// Call responder: accepts one opcode/argument call at a time, updates an accumulator, returns a held response.
// state   | meaning
// IDLE    | ready to accept a call
// EXEC    | multi-cycle MUL in progress
// RESP    | result presented, waiting for rsp_ready
module accum_responder
  import accum_pkg::*;
#(
  parameter int               WIDTH     = WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_arg,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_ovf,
  output logic             rsp_err,
  output logic             busy
);
  state_e             state;
  state_e             state_nxt;
  op_e                op;
  logic               accept;
  logic [WIDTH-1:0]   acc;
  logic               ovf_q;
  logic               err_q;
  logic [WIDTH:0]     sum;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  assign op     = op_e'(req_op);
  assign accept = req_valid && req_ready;
  assign sum    = {1'b0, acc} + {1'b0, req_arg};

  accum_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (accept && (op == OP_MUL)),
    .a       (acc),
    .b       (req_arg),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = (op == OP_MUL) ? ST_EXEC : ST_RESP;
      ST_EXEC: if (mul_done) state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_RESP);
    busy      = (state != ST_IDLE);
  end

  // Non-MUL results register on the accept edge; MUL lands on its final iteration.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc   <= RESET_VAL;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else if (accept) begin
      case (op)
        OP_NOP: begin
          ovf_q <= 1'b0;
          err_q <= 1'b0;
        end
        OP_ADD: begin
          acc   <= sum[WIDTH-1:0];
          ovf_q <= sum[WIDTH];
          err_q <= 1'b0;
        end
        OP_SUB: begin
          acc   <= acc - req_arg;
          ovf_q <= (req_arg > acc);
          err_q <= 1'b0;
        end
        OP_LOAD: begin
          acc   <= req_arg;
          ovf_q <= 1'b0;
          err_q <= 1'b0;
        end
        OP_CLR: begin
          acc   <= RESET_VAL;
          ovf_q <= 1'b0;
          err_q <= 1'b0;
        end
        OP_MUL: ;
        default: begin
          ovf_q <= 1'b0;
          err_q <= 1'b1;
        end
      endcase
    end else if ((state == ST_EXEC) && mul_done) begin
      acc   <= mul_product[WIDTH-1:0];
      ovf_q <= |mul_product[2*WIDTH-1:WIDTH];
      err_q <= 1'b0;
    end
  end

  assign rsp_data = acc;
  assign rsp_ovf  = ovf_q;
  assign rsp_err  = err_q;
endmodule

// File: tb/tb_accum_responder.sv
// Scoreboard bench for accum_responder: driver pushes model-predicted responses, monitor pops and compares.
module tb_accum_responder;
  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [2:0]   req_op = '0;
  logic [W-1:0] req_arg = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_data;
  logic         rsp_ovf;
  logic         rsp_err;
  logic         busy;

  accum_responder #(.WIDTH(W), .RESET_VAL('0)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_arg   (req_arg),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_ovf   (rsp_ovf),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int data;
    int ovf;
    int err;
    int lat;
    int acc_cyc;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   model_acc = 0;
  int   force_stall = -1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic modulo 256.
  task automatic issue(input int op, input int arg);
    exp_t e;
    int   budget;
    int   res;
    @(negedge clock);
    req_valid = 1'b1;
    req_op    = op[2:0];
    req_arg   = arg[W-1:0];
    budget    = 200;
    while (!req_ready && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: op %0d never accepted", op);
      req_valid = 1'b0;
      return;
    end
    e.ovf = 0;
    e.err = 0;
    e.lat = 1;
    case (op)
      0: ;
      1: begin res = model_acc + arg; e.ovf = (res > 255); model_acc = res % 256; end
      2: begin e.ovf = (arg > model_acc); model_acc = (model_acc - arg + 256) % 256; end
      3: model_acc = arg;
      4: model_acc = 0;
      5: begin res = model_acc * arg; e.ovf = (res > 255); model_acc = res % 256; e.lat = W + 1; end
      default: e.err = 1;
    endcase
    e.data    = model_acc;
    e.acc_cyc = cyc;
    sbq.push_back(e);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_op    = 3'($urandom);
    req_arg   = W'($urandom);
  endtask

  task automatic drain();
    int budget;
    budget = 300;
    while ((sbq.size() != 0 || busy) && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses still pending", sbq.size());
    end
  endtask

  // Monitor: compares first response cycle, then stability while stalled.
  initial begin
    int   remaining;
    bit   in_resp;
    bit   hs;
    exp_t cur;
    remaining = 0;
    in_resp   = 1'b0;
    hs        = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        in_resp   = 1'b0;
        hs        = 1'b0;
        rsp_ready = 1'b0;
      end else if (hs) begin
        hs = 1'b0;
        chk("idle_after_hs_valid", int'(rsp_valid), 0);
        chk("idle_after_hs_ready", int'(req_ready), 1);
        rsp_ready = 1'b0;
      end else if (rsp_valid) begin
        if (!in_resp) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: data %0d with no call pending", rsp_data);
            cur.data = int'(rsp_data);
            cur.ovf  = int'(rsp_ovf);
            cur.err  = int'(rsp_err);
          end else begin
            cur = sbq.pop_front();
            chk("rsp_data", int'(rsp_data), cur.data);
            chk("rsp_ovf", int'(rsp_ovf), cur.ovf);
            chk("rsp_err", int'(rsp_err), cur.err);
            chk("rsp_latency", cyc - cur.acc_cyc, cur.lat);
          end
          in_resp   = 1'b1;
          remaining = (force_stall >= 0) ? force_stall : int'($urandom_range(0, 3));
          force_stall = -1;
        end else begin
          chk("hold_data", int'(rsp_data), cur.data);
          chk("hold_ovf", int'(rsp_ovf), cur.ovf);
          chk("hold_err", int'(rsp_err), cur.err);
          chk("hold_req_ready", int'(req_ready), 0);
        end
        if (remaining == 0) begin
          rsp_ready = 1'b1;
          hs        = 1'b1;
          in_resp   = 1'b0;
        end else begin
          rsp_ready = 1'b0;
          remaining--;
        end
      end else begin
        if (busy) chk("exec_req_ready", int'(req_ready), 0);
        rsp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("reset_req_ready", int'(req_ready), 1);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_rsp_data", int'(rsp_data), 0);
    chk("reset_rsp_ovf", int'(rsp_ovf), 0);
    chk("reset_rsp_err", int'(rsp_err), 0);

    issue(1, 72);
    issue(1, 36);
    issue(3, 8'hF0);
    issue(1, 8'h20);
    issue(2, 8'h11);
    issue(3, 12);
    issue(5, 10);
    issue(5, 3);

    force_stall = 5;
    issue(1, 3);
    issue(1, 4);

    issue(3, 8'h55);
    issue(7, 0);
    issue(1, 1);
    issue(6, 9);
    issue(4, 0);
    drain();

    for (int i = 0; i < 60; i++) begin
      issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
    end
    drain();

    issue(3, 200);
    issue(1, 100);
    issue(5, 3);
    repeat (4) @(posedge clock);
    #2;
    chk("pre_reset_busy", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_rsp_valid", int'(rsp_valid), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_rsp_data", int'(rsp_data), 0);
    chk("async_rst_rsp_ovf", int'(rsp_ovf), 0);
    chk("async_rst_rsp_err", int'(rsp_err), 0);
    sbq.delete();
    model_acc = 0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_req_ready", int'(req_ready), 1);
    issue(0, 0);
    issue(1, 5);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
